// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter sharing one stb/ack stream sink between N_INPUTS producers,
// with a single-entry output register and optional burst locking of the grant.
module stream_arbiter #(
   parameter int N_INPUTS  = 4,
   parameter int WIDTH     = 16,
   parameter int SEL_W     = 2,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_INPUTS*WIDTH-1:0] in_data,
   input  logic [N_INPUTS-1:0]       in_stb,
   output logic [N_INPUTS-1:0]       in_ack,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_stb,
   input  logic                      out_ack,
   output logic [SEL_W-1:0]          grant_id,
   output logic                      busy
);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

   state_t                state, state_n;
   logic [N_INPUTS-1:0]   ack_n;
   logic [WIDTH-1:0]      data_n;
   logic                  stb_n;
   logic [SEL_W-1:0]      gid_n, last_ptr, ptr_n, sel;
   logic [CNT_W-1:0]      burst_cnt, cnt_n;
   logic [WIDTH-1:0]      words [N_INPUTS];

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_words
      assign words[g] = in_data[g*WIDTH +: WIDTH];
   end

   // Descending scan so the lowest offset from last_ptr+1 wins.
   always_comb begin
      sel = '0;
      for (int i = N_INPUTS - 1; i >= 0; i--) begin
         if (in_stb[SEL_W'((int'(last_ptr) + 1 + i) % N_INPUTS)])
            sel = SEL_W'((int'(last_ptr) + 1 + i) % N_INPUTS);
      end
   end

   always_comb begin
      state_n = state;
      ack_n   = in_ack;
      data_n  = out_data;
      stb_n   = out_stb;
      gid_n   = grant_id;
      ptr_n   = last_ptr;
      cnt_n   = burst_cnt;
      case (state)
         IDLE: if (|in_stb) begin
            gid_n   = sel;
            ack_n   = N_INPUTS'(1) << sel;
            state_n = ACCEPT;
         end
         ACCEPT: if (in_stb[grant_id] && in_ack[grant_id]) begin
            data_n  = words[grant_id];
            ack_n   = '0;
            stb_n   = 1'b1;
            cnt_n   = burst_cnt + CNT_W'(1);
            state_n = SEND;
         end
         SEND: if (out_ack) begin
            stb_n = 1'b0;
            if (burst_cnt < CNT_W'(BURST_LEN) && in_stb[grant_id]) begin
               ack_n   = N_INPUTS'(1) << grant_id;
               state_n = ACCEPT;
            end else begin
               ptr_n   = grant_id;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ack    <= '0;
         out_data  <= '0;
         out_stb   <= 1'b0;
         grant_id  <= '0;
         last_ptr  <= SEL_W'(N_INPUTS - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         in_ack    <= ack_n;
         out_data  <= data_n;
         out_stb   <= stb_n;
         grant_id  <= gid_n;
         last_ptr  <= ptr_n;
         burst_cnt <= cnt_n;
      end
   end

   assign busy = state != IDLE;
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed checks of stream_arbiter with queued producers and a recording sink;
// a second instance with BURST_LEN=1 checks pure word-level round robin.
module tb_stream_arbiter;
   logic        clk = 0, rst = 1, out_ack = 1;
   logic [63:0] in_data = '0;
   logic [3:0]  in_stb = '0, in_ack;
   logic [15:0] out_data;
   logic        out_stb, busy;
   logic [1:0]  grant_id;

   logic [63:0] in_data1 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
   logic [3:0]  in_stb1 = 4'hF, in_ack1;
   logic [15:0] out_data1;
   logic        out_stb1, busy1, out_ack1 = 1;
   logic [1:0]  grant_id1;

   int tests = 0, fails = 0;
   logic [15:0] mem [4][16];
   int wr [4] = '{0, 0, 0, 0}, rd [4] = '{0, 0, 0, 0}, xcnt [4] = '{0, 0, 0, 0};
   logic [15:0] rx [64], rx1 [8];
   logic [1:0]  rg [64];
   int rx_n = 0, rx1_n = 0;

   stream_arbiter #(.N_INPUTS(4), .WIDTH(16), .SEL_W(2), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
      .out_data(out_data), .out_stb(out_stb), .out_ack(out_ack), .grant_id(grant_id), .busy(busy));

   stream_arbiter #(.N_INPUTS(4), .WIDTH(16), .SEL_W(2), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_stb(in_stb1), .in_ack(in_ack1),
      .out_data(out_data1), .out_stb(out_stb1), .out_ack(out_ack1), .grant_id(grant_id1), .busy(busy1));

   always #5 clk = ~clk;

   // Handshakes are sampled at the edge; queues and source pins update 1 time unit later.
   always begin
      logic [3:0]  xs;
      logic        xo, xo1;
      logic [15:0] d, d1;
      logic [1:0]  g;
      @(posedge clk);
      xs = in_stb & in_ack; xo = out_stb & out_ack; xo1 = out_stb1 & out_ack1;
      d = out_data; d1 = out_data1; g = grant_id;
      #1;
      for (int i = 0; i < 4; i++) if (xs[i]) begin rd[i]++; xcnt[i]++; end
      if (xo && rx_n < 64) begin rx[rx_n] = d; rg[rx_n] = g; rx_n++; end
      if (xo1 && rx1_n < 8) begin rx1[rx1_n] = d1; rx1_n++; end
      for (int i = 0; i < 4; i++) begin
         in_stb[i] = wr[i] != rd[i];
         in_data[i*16 +: 16] = (wr[i] != rd[i]) ? mem[i][rd[i]] : 16'h0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [15:0] w);
      mem[i][wr[i]] = w;
      wr[i]++;
   endtask

   task automatic wait_rx(input int n);
      for (int c = 0; c < 400 && rx_n < n; c++) @(negedge clk);
      check("rx_count", rx_n, n);
   endtask

   initial begin
      logic [15:0] e3 [7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h1001, 16'h0005, 16'h0006};
      logic [15:0] e6 [8] = '{16'h3001, 16'h3002, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h2001, 16'h1005};
      logic [1:0]  g6 [8] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      int x0;
      repeat (2) @(negedge clk);
      check("rst_out_stb", out_stb, 0);
      check("rst_in_ack", in_ack, 0);
      check("rst_out_data", out_data, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      rst = 0;

      for (int c = 0; c < 200 && rx1_n < 6; c++) @(negedge clk);
      check("rr_count", rx1_n, 6);
      for (int k = 0; k < 6; k++) check("rr_order", rx1[k], 16'hA000 + 16'(k % 4));

      rx_n = 0; x0 = xcnt[2];
      push(2, 16'h1234);
      wait_rx(1);
      check("single_data", rx[0], 16'h1234);
      check("single_gid", rg[0], 2);
      repeat (3) @(negedge clk);
      check("single_xfers", xcnt[2] - x0, 1);
      check("single_busy", busy, 0);
      check("single_stb", out_stb, 0);
      check("single_gid_hold", grant_id, 2);

      rx_n = 0;
      for (int k = 1; k <= 6; k++) push(0, 16'(k));
      push(1, 16'h1001);
      wait_rx(7);
      for (int k = 0; k < 7; k++) check("burst_order", rx[k], e3[k]);

      rx_n = 0; x0 = xcnt[1]; out_ack = 0;
      for (int k = 1; k <= 3; k++) push(1, 16'h4000 + 16'(k));
      for (int c = 0; c < 50 && !out_stb; c++) @(negedge clk);
      check("bp_stb_rise", out_stb, 1);
      for (int k = 0; k < 10; k++) begin
         check("bp_stb", out_stb, 1);
         check("bp_data", out_data, 16'h4001);
         check("bp_in_ack", in_ack, 0);
         @(negedge clk);
      end
      out_ack = 1;
      wait_rx(3);
      for (int k = 0; k < 3; k++) check("bp_order", rx[k], 16'h4001 + 16'(k));
      check("bp_sent", xcnt[1] - x0, 3);

      rx_n = 0; out_ack = 0;
      push(2, 16'h5555);
      for (int c = 0; c < 50 && !out_stb; c++) @(negedge clk);
      check("rst_mid_data", out_data, 16'h5555);
      rst = 1;
      push(1, 16'h5101);
      push(0, 16'h5001);
      @(negedge clk);
      check("rst_mid_stb", out_stb, 0);
      check("rst_mid_ack", in_ack, 0);
      check("rst_mid_busy", busy, 0);
      rst = 0; out_ack = 1;
      wait_rx(2);
      check("rst_first_data", rx[0], 16'h5001);
      check("rst_first_gid", rg[0], 0);
      check("rst_second_data", rx[1], 16'h5101);

      rx_n = 0;
      push(3, 16'h3001);
      push(3, 16'h3002);
      for (int c = 0; c < 50 && !in_ack[3]; c++) @(negedge clk);
      check("drop_grant3", in_ack[3], 1);
      for (int k = 1; k <= 5; k++) push(1, 16'h1000 + 16'(k));
      push(2, 16'h2001);
      wait_rx(8);
      for (int k = 0; k < 8; k++) begin
         check("drop_data", rx[k], e6[k]);
         check("drop_gid", rg[k], g6[k]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
